// File: rtl/cpu_step_sequencer_if.sv
// Sequencer bus: operator/control-unit inputs and the commit-side outputs.
// master = the side driving the button/decode flags, slave = the sequencer.
interface cpu_step_sequencer_if #(
  parameter int SW_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 run_mode;
  logic                 step_pulse;
  logic                 is_in;
  logic                 is_out;
  logic                 halt_in;
  logic [SW_WIDTH-1:0]  switches;
  logic                 cpu_en;
  logic [SW_WIDTH-1:0]  in_data;
  logic                 in_wait;
  logic                 out_strobe;
  logic                 halted;
  logic [2:0]           state_dbg;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    output run_mode, step_pulse, is_in, is_out, halt_in, switches,
    input  cpu_en, in_data, in_wait, out_strobe, halted, state_dbg, instr_count
  );

  modport slave (
    input  run_mode, step_pulse, is_in, is_out, halt_in, switches,
    output cpu_en, in_data, in_wait, out_strobe, halted, state_dbg, instr_count
  );
endinterface

// File: rtl/cpu_step_sequencer.sv
// Execution sequencer for the single-cycle datapath: produces the one-cycle
// commit enable in free-run or single-step mode, stalls on IN until the
// operator confirms, and stops for good on HALT. All outputs are registered.
module cpu_step_sequencer #(
  parameter int SW_WIDTH  = 16,
  parameter int RUN_DIV   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_step_sequencer_if.slave   bus
);

  localparam int               DIV_W    = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EXEC      = 3'd1,
    S_WAIT_IN   = 3'd2,
    S_COMMIT_IN = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t               r_state;
  logic [DIV_W-1:0]     r_div;
  logic                 r_cpu_en;
  logic                 r_out_strobe;
  logic                 r_in_wait;
  logic                 r_halted;
  logic [SW_WIDTH-1:0]  r_in_data;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_div_last;
  logic [DIV_W-1:0]     w_div_next;

  // Run-mode divider: counts 0..RUN_DIV-1 and wraps.
  assign w_div_last = (r_div == DIV_LAST);
  assign w_div_next = w_div_last ? '0 : r_div + 1'b1;

  // Sequencer FSM. cpu_en/out_strobe default low so every enable is one cycle.
  // While cpu_en is high no issue decision is taken, giving decode a cycle
  // to see the next instruction before the following commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_cpu_en     <= 1'b0;
      r_out_strobe <= 1'b0;
      r_in_wait    <= 1'b0;
      r_halted     <= 1'b0;
      r_in_data    <= '0;
      r_cnt        <= '0;
    end else begin
      r_cpu_en     <= 1'b0;
      r_out_strobe <= 1'b0;
      if (r_cpu_en) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.step_pulse) begin
            r_state <= S_EXEC;
            r_div   <= '0;
          end
        end
        S_EXEC: begin
          if (r_cpu_en) begin
            // commit cycle: divider keeps running in run mode, steps dropped
            r_div <= bus.run_mode ? w_div_next : '0;
          end else if (bus.halt_in) begin
            // HALT itself is never committed
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (bus.is_in) begin
            r_state   <= S_WAIT_IN;
            r_in_wait <= 1'b1;
          end else if (bus.run_mode) begin
            r_div <= w_div_next;
            if (w_div_last) begin
              r_cpu_en     <= 1'b1;
              r_out_strobe <= bus.is_out;
            end
          end else begin
            r_div <= '0;
            if (bus.step_pulse) begin
              r_cpu_en     <= 1'b1;
              r_out_strobe <= bus.is_out;
            end
          end
        end
        S_WAIT_IN: begin
          // confirmation latches the switches and commits IN in COMMIT_IN
          if (bus.step_pulse) begin
            r_in_data <= bus.switches;
            r_in_wait <= 1'b0;
            r_state   <= S_COMMIT_IN;
            r_cpu_en  <= 1'b1;
          end
        end
        S_COMMIT_IN: begin
          r_state <= S_EXEC;
          r_div   <= '0;
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_en      = r_cpu_en;
  assign bus.out_strobe  = r_out_strobe;
  assign bus.in_wait     = r_in_wait;
  assign bus.halted      = r_halted;
  assign bus.in_data     = r_in_data;
  assign bus.instr_count = r_cnt;
  assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench for cpu_step_sequencer. Main instance uses the default
// parameters; a small-counter instance covers the instr_count wrap.
module tb_cpu_step_sequencer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cpu_step_sequencer_if #(.SW_WIDTH(16), .CNT_WIDTH(16)) bus ();
  cpu_step_sequencer_if #(.SW_WIDTH(16), .CNT_WIDTH(4))  wbus ();

  cpu_step_sequencer #(.SW_WIDTH(16), .RUN_DIV(4), .CNT_WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cpu_step_sequencer #(.SW_WIDTH(16), .RUN_DIV(2), .CNT_WIDTH(4)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"},  32'(bus.state_dbg),   32'd0);
    chk({tag, ".en"},     32'(bus.cpu_en),      32'd0);
    chk({tag, ".strobe"}, 32'(bus.out_strobe),  32'd0);
    chk({tag, ".wait"},   32'(bus.in_wait),     32'd0);
    chk({tag, ".halted"}, 32'(bus.halted),      32'd0);
    chk({tag, ".in_data"},32'(bus.in_data),     32'd0);
    chk({tag, ".count"},  32'(bus.instr_count), 32'd0);
  endtask

  initial begin
    int ens;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.run_mode = 1'b0;  bus.step_pulse = 1'b0; bus.is_in = 1'b0;
    bus.is_out   = 1'b0;  bus.halt_in    = 1'b0; bus.switches = 16'h0;
    wbus.run_mode = 1'b0; wbus.step_pulse = 1'b0; wbus.is_in = 1'b0;
    wbus.is_out   = 1'b0; wbus.halt_in    = 1'b0; wbus.switches = 16'h0;
    tick(); tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    chk("idle_hold", 32'(bus.state_dbg), 32'd0);

    // 1: free run, RUN_DIV=4 -> commit 4 cycles after EXEC entry, then every 4
    bus.run_mode = 1'b1; bus.step_pulse = 1'b1;
    tick();
    bus.step_pulse = 1'b0;
    chk("exec_entry", 32'(bus.state_dbg), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("run_en[%0d]", k), 32'(bus.cpu_en), 32'((k % 4) == 0));
    end
    tick();
    chk("run_count5", 32'(bus.instr_count), 32'd5);

    // 4: OUT instructions -> strobe exactly with cpu_en
    bus.is_out = 1'b1;
    for (int k = 22; k <= 33; k++) begin
      tick();
      chk($sformatf("out_en[%0d]", k),     32'(bus.cpu_en),     32'((k % 4) == 0));
      chk($sformatf("out_strb[%0d]", k),   32'(bus.out_strobe), 32'((k % 4) == 0));
    end
    chk("out_count", 32'(bus.instr_count), 32'd8);
    bus.is_out = 1'b0;

    // 2: single step, three pulses 10 cycles apart
    bus.run_mode = 1'b0;
    tick();
    chk("step_idle", 32'(bus.cpu_en), 32'd0);
    for (int p = 0; p < 3; p++) begin
      bus.step_pulse = 1'b1;
      tick();
      bus.step_pulse = 1'b0;
      chk($sformatf("step_en[%0d]", p), 32'(bus.cpu_en), 32'd1);
      ens = 0;
      for (int c = 0; c < 9; c++) begin
        tick();
        ens += int'(bus.cpu_en);
      end
      chk($sformatf("step_quiet[%0d]", p), 32'(ens), 32'd0);
    end
    chk("step_count", 32'(bus.instr_count), 32'd11);
    // step held into the cpu_en cycle is dropped
    bus.step_pulse = 1'b1;
    tick();
    chk("coinc_en1", 32'(bus.cpu_en), 32'd1);
    tick();
    bus.step_pulse = 1'b0;
    chk("coinc_drop", 32'(bus.cpu_en), 32'd0);
    tick();
    chk("coinc_quiet", 32'(bus.cpu_en), 32'd0);
    tick();
    chk("coinc_count", 32'(bus.instr_count), 32'd12);

    // 3: IN stall, then confirm with the switch value
    bus.is_in = 1'b1; bus.switches = 16'h1234;
    tick();
    chk("in_state", 32'(bus.state_dbg), 32'd2);
    chk("in_wait",  32'(bus.in_wait),   32'd1);
    ens = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      ens += int'(bus.cpu_en);
    end
    chk("in_stall_en", 32'(ens), 32'd0);
    chk("in_stall_state", 32'(bus.state_dbg), 32'd2);
    bus.switches = 16'hBEEF; bus.step_pulse = 1'b1;
    tick();
    bus.step_pulse = 1'b0; bus.is_in = 1'b0;
    chk("cin_state",  32'(bus.state_dbg),  32'd3);
    chk("cin_en",     32'(bus.cpu_en),     32'd1);
    chk("cin_data",   32'(bus.in_data),    32'hBEEF);
    chk("cin_wait",   32'(bus.in_wait),    32'd0);
    chk("cin_strobe", 32'(bus.out_strobe), 32'd0);
    tick();
    bus.switches = 16'h0F0F;
    chk("cin_exec", 32'(bus.state_dbg), 32'd1);
    chk("cin_en0",  32'(bus.cpu_en),    32'd0);
    chk("cin_count",32'(bus.instr_count), 32'd13);
    tick();
    chk("in_hold", 32'(bus.in_data), 32'hBEEF);

    // 5: HALT beats IN; terminal
    bus.halt_in = 1'b1; bus.is_in = 1'b1;
    tick();
    chk("halt_state",  32'(bus.state_dbg), 32'd4);
    chk("halt_flag",   32'(bus.halted),    32'd1);
    chk("halt_nowait", 32'(bus.in_wait),   32'd0);
    bus.halt_in = 1'b0; bus.is_in = 1'b0; bus.run_mode = 1'b1;
    ens = 0;
    for (int c = 0; c < 20; c++) begin
      bus.step_pulse = (c % 3 == 0);
      tick();
      ens += int'(bus.cpu_en);
    end
    bus.step_pulse = 1'b0;
    chk("halt_en",    32'(ens),             32'd0);
    chk("halt_stay",  32'(bus.state_dbg),   32'd4);
    chk("halt_count", 32'(bus.instr_count), 32'd13);

    // 6: reset is immediate, then reset during WAIT_IN with a step pending
    rst = 1'b1;
    #1;
    chk("async_state",  32'(bus.state_dbg), 32'd0);
    chk("async_halted", 32'(bus.halted),    32'd0);
    tick();
    rst = 1'b0; bus.run_mode = 1'b0; bus.step_pulse = 1'b1;
    tick();
    bus.step_pulse = 1'b0; bus.is_in = 1'b1;
    tick();
    chk("r6_wait", 32'(bus.state_dbg), 32'd2);
    bus.switches = 16'h5A5A; bus.step_pulse = 1'b1;
    tick();
    bus.step_pulse = 1'b0;
    chk("r6_data", 32'(bus.in_data), 32'h5A5A);
    tick();
    tick();
    chk("r6_rewait", 32'(bus.state_dbg), 32'd2);
    bus.step_pulse = 1'b1; rst = 1'b1;
    tick();
    chk_reset("r6");
    bus.step_pulse = 1'b0; bus.is_in = 1'b0; rst = 1'b0;
    tick();

    // counter wrap on the 4-bit instance (RUN_DIV=2: commit every 2 cycles)
    wbus.run_mode = 1'b1; wbus.step_pulse = 1'b1;
    tick();
    wbus.step_pulse = 1'b0;
    for (int c = 0; c < 31; c++) tick();
    chk("wrap_full", 32'(wbus.instr_count), 32'hF);
    tick();
    chk("wrap_en", 32'(wbus.cpu_en), 32'd1);
    tick();
    chk("wrap_zero", 32'(wbus.instr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_step_sequencer.md
Name: cpu_step_sequencer

Overview:
Central execution sequencer for the single-cycle MIPS datapath on the FPGA board. Generates a one-cycle commit enable (cpu_en) that gates every state-changing element: PC update, register-bank write, data-memory write and output-module write. Supports free-run and single-step modes, stalls on IN instructions until the operator confirms the switch value, and stops permanently on HALT. Sits between the debounced/one-shot button path, the control unit's decoded opcode flags, and the datapath's write enables.

Parameters:
SW_WIDTH, 16, width of the switch input and latched input data
RUN_DIV, 4, clk cycles per instruction in run mode; legal range 2..65535
CNT_WIDTH, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
run_mode  in  1  1 = free-run, 0 = single-step; level, may change at any time
step_pulse  in  1  one-cycle pulse from the one-shot button path (start / step / confirm input)
is_in  in  1  current instruction is IN (from control unit)
is_out  in  1  current instruction is OUT (from control unit)
halt_in  in  1  current instruction is HALT (from control unit)
switches  in  SW_WIDTH  board switches
cpu_en  out  1  one-cycle commit enable for PC, register bank, data memory and output module
in_data  out  SW_WIDTH  switch value latched on IN confirmation; feeds the immediate mux
in_wait  out  1  high while waiting for operator input
out_strobe  out  1  high with cpu_en when the committed instruction is OUT
halted  out  1  high in HALT state
state_dbg  out  3  encoded state: IDLE=0, EXEC=1, WAIT_IN=2, COMMIT_IN=3, HALT=4
instr_count  out  CNT_WIDTH  instructions committed since reset

Behaviour:
- Reset, asynchronous and immediate: state IDLE, cpu_en=0, out_strobe=0, in_wait=0, halted=0, in_data=0, instr_count=0, divider=0. Reset wins over every simultaneous event.
- All outputs are registered. The decision is made in cycle t from the current is_in, is_out, halt_in and step_pulse; the effect appears in cycle t+1.
- IDLE: no cpu_en. A step_pulse moves to EXEC and clears the divider, regardless of run_mode.
- EXEC priority, evaluated each cycle while cpu_en=0:
  1. halt_in=1: go to HALT. No cpu_en; the HALT instruction is not committed.
  2. is_in=1: go to WAIT_IN, in_wait=1. No cpu_en.
  3. Otherwise issue:
     - run_mode=1: the divider counts 0..RUN_DIV-1. At RUN_DIV-1, cpu_en=1 next cycle and the divider wraps to 0.
     - run_mode=0: the divider is held at 0. A step_pulse gives cpu_en=1 next cycle.
- While cpu_en=1, no new issue decision is made and a step_pulse in that cycle is dropped. This guarantees at least one cycle between pulses, so decode sees the new instruction. The divider keeps counting in run mode.
- out_strobe equals is_out as sampled at the issue decision. It is asserted in the same cycle as cpu_en.
- WAIT_IN: in_wait=1 in both modes. On step_pulse: in_data <= switches, in_wait=0 next cycle, go to COMMIT_IN. All other inputs are ignored.
- COMMIT_IN: cpu_en=1 for exactly one cycle, which commits the IN instruction. Then go to EXEC with the divider cleared. The IN flag is not re-evaluated in COMMIT_IN.
- HALT: halted=1, cpu_en=0. Terminal until rst; step_pulse and run_mode are ignored.
- instr_count increments by 1 on every cycle with cpu_en=1, wrapping from 2^CNT_WIDTH-1 to 0.
- Switching run_mode mid-run takes effect on the next decision cycle; going to 0 clears the divider.
- in_data holds its value until the next IN confirmation or reset.

Test Plan:
1. Reset, then step_pulse, run_mode=1, RUN_DIV=4, no flags -> cpu_en pulses every 4 cycles, the first 4 cycles after EXEC entry; instr_count=5 after 5 pulses.
2. run_mode=0 in EXEC, three step_pulses 10 cycles apart -> exactly three single-cycle cpu_en pulses, each one cycle after its step_pulse. A step_pulse coinciding with cpu_en -> no extra pulse.
3. is_in=1 with switches=16'hBEEF -> WAIT_IN with in_wait=1 and no cpu_en for 100 cycles. step_pulse -> in_data=16'hBEEF, state COMMIT_IN, one cpu_en, then EXEC with state_dbg=1.
4. is_out=1 in run mode -> out_strobe high in exactly the cycles where cpu_en is high; never otherwise.
5. halt_in=1 and is_in=1 together in EXEC -> HALT (state_dbg=4), halted=1, cpu_en stays 0 for the rest of the run despite step_pulses.
6. rst asserted mid-WAIT_IN with step_pulse high -> all outputs at reset values, in_data=0; instr_count=16'hFFFF plus one cpu_en -> instr_count=0.
